// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//
// Purpose: groups the operand/result handshake of the bit-serial subtractor
// so that the switch/LED wrapper and the subtractor share one bundle.
//
// Signals (WIDTH = operand/result width):
//   start       master -> slave  request an operation
//   minuend     master -> slave  operand A, captured on an accepted start
//   subtrahend  master -> slave  operand B, captured on an accepted start
//   busy        slave  -> master high while bits are being processed
//   done        slave  -> master one-cycle pulse when the result is valid
//   difference  slave  -> master A - B modulo 2^WIDTH, registered
//   borrow      slave  -> master high when A < B (unsigned), registered
//   overflow    slave  -> master signed overflow, registered
//                                (present only with SERIAL_SUB_OVERFLOW_EN)
//
// Build option: `define SERIAL_SUB_OVERFLOW_EN adds the overflow signal.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] difference;
    logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;

    // Requesting side: switches / wrapper logic.
    modport master (
        output start, minuend, subtrahend,
        input  busy, done, difference, borrow, overflow
    );

    // Serving side: the subtractor itself.
    modport slave (
        input  start, minuend, subtrahend,
        output busy, done, difference, borrow, overflow
    );
`else
    // Requesting side: switches / wrapper logic.
    modport master (
        output start, minuend, subtrahend,
        input  busy, done, difference, borrow
    );

    // Serving side: the subtractor itself.
    modport slave (
        input  start, minuend, subtrahend,
        output busy, done, difference, borrow
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//
// Purpose: bit-serial subtractor that recovers one adder operand from a sum
// and the other operand: difference = minuend - subtrahend, plus borrow.
// One bit per clock, LSB first, through a single full-subtractor cell and a
// borrow flip-flop. A result appears WIDTH cycles after an accepted start.
//
// Ports:
//   clk    input   system clock, all state updates on the rising edge
//   rst_n  input   synchronous reset, active-low
//   bus    slave   serial_subtractor_if (start/operands in, busy/done/results out)
//
// Parameters:
//   WIDTH  operand and result width in bits (>= 2)
//
// Build option: `define SERIAL_SUB_OVERFLOW_EN adds the registered
// two's-complement overflow output.
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_bor;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             r_ovf;
`endif

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic             w_accept;

    // Full-subtractor cell working on the current LSBs of the operand
    // shift registers and the stored borrow from the previous bit.
    assign w_a    = r_a[0];
    assign w_b    = r_b[0];
    assign w_d    = w_a ^ w_b ^ r_bor;
    assign w_bout = (~w_a & w_b) | (~(w_a ^ w_b) & r_bor);

    // The counter holds the index of the bit being processed, so the edge
    // with count WIDTH-1 is the one that finishes the word.
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));

    // A start only counts when no word is in flight.
    assign w_accept = bus.start && ((r_state == IDLE) || (r_state == DONE));

    // State register of the control FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and status outputs. busy and done decode directly from the
    // registered state, so both change only on clock edges.
    always_comb begin
        w_next   = r_state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                w_next   = bus.start ? SHIFT : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Datapath: operand capture, serial shifting and result latching.
    // The result register fills from the MSB end so that after WIDTH shifts
    // bit 0 of the difference sits in bit 0. On the last edge the fresh
    // difference bit has not yet reached r_res, so the output is built from
    // w_d and the upper part of r_res. At that point r_a[0]/r_b[0] are the
    // operand sign bits, which is what the overflow term needs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bor    <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_ovf    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a   <= bus.minuend;
            r_b   <= bus.subtrahend;
            r_res <= '0;
            r_bor <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= {w_d, r_res[WIDTH-1:1]};
            r_bor <= w_bout;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff   <= {w_d, r_res[WIDTH-1:1]};
                r_borrow <= w_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                r_ovf    <= (w_a != w_b) && (w_d != w_a);
`endif
            end
        end
    end

    assign bus.difference = r_diff;
    assign bus.borrow     = r_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign bus.overflow   = r_ovf;
`endif

endmodule
